// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int INSTR_W_DEF = 32;
    localparam int ADDR_W_DEF  = 64;

    // Sequential fetch stride in bytes.
    localparam int unsigned PC_INCR = 4;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Bundle of redirect, imem request/response and IF dequeue signals.
// Latency: none (wires only).
// Backpressure: IF pulls with deq; imem requests are gated inside the queue.
interface fetch_prefetch_queue_if #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = fetch_pkg::ADDR_W_DEF,
    parameter int INSTR_W = fetch_pkg::INSTR_W_DEF
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               deq;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [CNT_W-1:0]   count;

    // Environment side: drives redirect, memory responses and dequeue.
    modport master (
        output redirect, redirect_pc, imem_valid, imem_rdata, deq,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, count
    );

    // Queue side.
    modport slave (
        input  redirect, redirect_pc, imem_valid, imem_rdata, deq,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, count
    );

endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// Circular buffer of DEPTH entries with head/tail pointers and occupancy count.
// Latency: a write is readable at the head the cycle after wr_en.
// Backpressure: none internally; the caller never writes when full or reads when empty.
module prefetch_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    input  logic                         flush,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    // Storage array; a flush cancels the write that shares its cycle.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_q[tail_q] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) tail_q <= tail_q + PTR_W'(1);
            if (rd_en) head_q <= head_q + PTR_W'(1);
            if (wr_en && !rd_en)      count_q <= count_q + CNT_W'(1);
            else if (!wr_en && rd_en) count_q <= count_q - CNT_W'(1);
        end
    end

    assign rd_data = mem_q[head_q];
    assign count   = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher with a DEPTH-entry buffer; optional bypass via PREFETCH_BYPASS_EN.
// Latency: response visible at head 1 cycle after imem_valid (0 cycles with bypass into an empty buffer).
// Backpressure: one outstanding fetch, issued only while the buffer has room; IF pops with deq.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_prefetch_queue_if.slave bus
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_rd_data;
    logic                fifo_nonempty;
    logic                fifo_wr_en;
    logic                fifo_rd_en;
    logic                req_issue;
    logic                rsp_accept;
    logic                bypass_hit;

    assign fifo_nonempty = (fifo_count != '0);

    // A response counts only while waiting for it and not killed by a redirect.
    assign rsp_accept = (state_q == WAIT) && bus.imem_valid && !bus.redirect;

`ifdef PREFETCH_BYPASS_EN
    assign bypass_hit = rsp_accept && !fifo_nonempty;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed response consumed in the same cycle never enters the buffer.
    assign fifo_wr_en = rsp_accept && !(bypass_hit && bus.deq);
    assign fifo_rd_en = bus.deq && fifo_nonempty && !bus.redirect;

    // In FETCH nothing is outstanding, so free space is simply count < DEPTH.
    assign req_issue = (state_q == FETCH) && (fifo_count < CNT_W'(DEPTH))
                     && !bus.redirect && !reset;

    assign bus.imem_req  = req_issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.count     = fifo_count;

    prefetch_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr_en),
        .wr_data ({bus.imem_rdata, fetch_pc_q}),
        .rd_en   (fifo_rd_en),
        .flush   (bus.redirect),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    // Next-state and fetch PC; redirect overrides every other event.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            state_d    = (state_q == WAIT && !bus.imem_valid) ? DISCARD : FETCH;
        end else begin
            case (state_q)
                FETCH:   if (req_issue) state_d = WAIT;
                WAIT: begin
                    if (bus.imem_valid) begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INCR);
                        state_d    = FETCH;
                    end
                end
                DISCARD: if (bus.imem_valid) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // State and fetch PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Head presentation: buffered entry first, otherwise the bypassed response, else zeros.
    always_comb begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.instr_pc    = '0;
        if (fifo_nonempty) begin
            bus.instr_valid = 1'b1;
            bus.instr       = fifo_rd_data[ADDR_W +: INSTR_W];
            bus.instr_pc    = fifo_rd_data[ADDR_W-1:0];
        end else if (bypass_hit) begin
            bus.instr_valid = 1'b1;
            bus.instr       = bus.imem_rdata;
            bus.instr_pc    = fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for the prefetch queue with a dequeue scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_prefetch_queue;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    fetch_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    logic [63:0] exp_q [$];

    logic        rsp_en     = 1'b0;
    logic        auto_valid = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic        man_valid  = 1'b0;
    logic [31:0] man_rdata  = '0;

    assign bus.imem_valid = auto_valid | man_valid;
    assign bus.imem_rdata = man_valid ? man_rdata : auto_rdata;

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] ifn(input logic [63:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Memory model: answers each sampled request one cycle later.
    always begin : responder
        logic [63:0] a;
        @(negedge clk);
        if (rsp_en && bus.imem_req) begin
            a = bus.imem_addr;
            @(posedge clk);
            #1;
            auto_valid = 1'b1;
            auto_rdata = ifn(a);
            @(posedge clk);
            #1;
            auto_valid = 1'b0;
        end
    end

    // Scoreboard monitor: every head pop is checked against the expected queue.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && !bus.redirect && bus.instr_valid && bus.deq) begin
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL pop_extra: popped pc %0h with nothing expected", bus.instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", bus.instr_pc, e);
                chk("pop_instr", {32'h0, bus.instr}, {32'h0, ifn(e)});
            end
        end
    end

    initial begin
        int n;
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.deq         = 1'b0;

        // Reset values
        cyc(); smp();
        chk("rst_count", bus.count, 0);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_pc", bus.instr_pc, 0);

        // 1: fill with a 1-cycle memory
        cyc();
        reset  = 1'b0;
        rsp_en = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(64'(i * 4));
        smp();
        chk("t1_req0", bus.imem_req, 1);
        chk("t1_addr0", bus.imem_addr, 0);
        n = 0;
        while (bus.count != 3'd4 && n < 40) begin cyc(); n++; end
        chk("t1_fill", bus.count, 4);
        cyc(); smp();
        chk("t1_req_full", bus.imem_req, 0);
        chk("t1_head_pc", bus.instr_pc, 0);
        chk("t1_head_instr", bus.instr, ifn(64'h0));

        // 2: drain with deq held; fetch resumes at 0x10
        cyc();
        bus.deq = 1'b1;
        smp();
        chk("t2_req_full", bus.imem_req, 0);
        cyc(); smp();
        chk("t2_req_resume", bus.imem_req, 1);
        chk("t2_addr_resume", bus.imem_addr, 64'h10);
        chk("t2_count", bus.count, 3);
        for (int i = 0; i < 8; i++) begin cyc(); smp(); end
        cyc();
        bus.deq = 1'b0;
        rsp_en  = 1'b0;
        chk("t2_popped", exp_q.size(), 4);
        cyc(); cyc();

        // 3: redirect in WAIT, stale response two cycles later
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h100;
        exp_q.delete();
        smp();
        chk("t3_req_redir", bus.imem_req, 0);
        cyc();
        bus.redirect = 1'b0;
        smp();
        chk("t3_count", bus.count, 0);
        chk("t3_req_discard", bus.imem_req, 0);
        cyc();
        man_valid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        cyc();
        man_valid = 1'b0;
        smp();
        chk("t3_req", bus.imem_req, 1);
        chk("t3_addr", bus.imem_addr, 64'h100);
        chk("t3_count_drop", bus.count, 0);
        cyc();
        man_valid = 1'b1; man_rdata = ifn(64'h100);
        cyc();
        man_valid = 1'b0;
        smp();
        chk("t3_head_pc", bus.instr_pc, 64'h100);
        chk("t3_head_instr", bus.instr, ifn(64'h100));
        chk("t3_addr_next", bus.imem_addr, 64'h104);
        cyc();
        man_valid = 1'b1; man_rdata = ifn(64'h104);
        cyc();
        man_valid = 1'b0;

        // 5: redirect and response together with two entries buffered
        cyc();
        man_valid = 1'b1; man_rdata = ifn(64'h108);
        bus.redirect = 1'b1; bus.redirect_pc = 64'h200;
        smp();
        chk("t5_count_before", bus.count, 2);
        chk("t5_req", bus.imem_req, 0);
        cyc();
        man_valid = 1'b0; bus.redirect = 1'b0;

        // 4: deq on an empty buffer
        bus.deq = 1'b1;
        smp();
        chk("t5_count", bus.count, 0);
        chk("t4_valid", bus.instr_valid, 0);
        chk("t4_instr", bus.instr, 0);
        chk("t4_pc", bus.instr_pc, 0);
        chk("t5_req_new", bus.imem_req, 1);
        chk("t5_addr_new", bus.imem_addr, 64'h200);
        cyc();
        bus.deq = 1'b0;
        smp();
        chk("t4_count", bus.count, 0);
        chk("t4_addr_hold", bus.imem_addr, 64'h200);

        // 6: PC wrap, then reset during WAIT with a late response
        bus.redirect = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        bus.redirect = 1'b0;
        man_valid = 1'b1; man_rdata = 32'h0BAD_0BAD;
        cyc();
        man_valid = 1'b0;
        smp();
        chk("t6_addr_top", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        man_valid = 1'b1; man_rdata = ifn(64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        man_valid = 1'b0;
        smp();
        chk("t6_wrap_addr", bus.imem_addr, 0);
        chk("t6_wrap_req", bus.imem_req, 1);
        chk("t6_head_pc", bus.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        man_valid = 1'b1; man_rdata = 32'h1234_5678;
        smp();
        chk("t6_rst_count", bus.count, 0);
        chk("t6_rst_addr", bus.imem_addr, 0);
        cyc();
        man_valid = 1'b0;
        smp();
        chk("t6_late_count", bus.count, 0);
        chk("t6_late_valid", bus.instr_valid, 0);

        // 7: response into an empty buffer with deq asserted
        cyc();
        man_valid = 1'b1; man_rdata = ifn(64'h0);
        bus.deq = 1'b1;
        exp_q.push_back(64'h0);
`ifdef PREFETCH_BYPASS_EN
        smp();
        chk("t7_bypass_valid", bus.instr_valid, 1);
        chk("t7_bypass_pc", bus.instr_pc, 0);
        cyc();
        man_valid = 1'b0; bus.deq = 1'b0;
        smp();
        chk("t7_count", bus.count, 0);
`else
        smp();
        chk("t7_same_cycle_valid", bus.instr_valid, 0);
        cyc();
        man_valid = 1'b0;
        smp();
        chk("t7_next_valid", bus.instr_valid, 1);
        chk("t7_next_pc", bus.instr_pc, 0);
        cyc();
        bus.deq = 1'b0;
        smp();
        chk("t7_count", bus.count, 0);
`endif
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
